// File: rtl/if_stage_pkg.sv
// Shared CPU pipeline constants and fetch-stage state encoding.
// The decode stage reuses the bus widths defined here.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
   localparam int unsigned FS_TO_DS_BUS_WD = 64;
   localparam int unsigned BR_BUS_WD       = 33;

   // Encoding is {fs_valid, inst_buf_valid}, so both flags read straight off the state bits.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      LIVE  = 2'b10,
      HOLD  = 2'b11
   } fs_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: decode handshake, redirect and instruction SRAM port.
// master is the fetch-stage view; slave is the decode/SRAM/environment view.
interface if_stage_if;

   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        inst_sram_en;
   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      input  ds_allowin, br_taken, br_target, inst_sram_rdata,
      output fs_to_ds_valid, fs_pc, fs_inst,
             inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
   );

   modport slave (
      output ds_allowin, br_taken, br_target, inst_sram_rdata,
      input  fs_to_ds_valid, fs_pc, fs_inst,
             inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
   );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one SRAM read per cycle toward nextpc and
// buffers the returned instruction while decode stalls; a taken branch redirects at once.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        inst_sram_en,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
);

   import if_stage_pkg::*;

   fs_state_t   state, state_nxt;
   logic        fs_valid;
   logic        fs_allowin;
   logic [31:0] nextpc;
   logic [31:0] inst_buf, inst_buf_nxt;

   assign fs_valid = state[1];

   always_comb begin
      fs_allowin   = ~fs_valid | ds_allowin | br_taken;
      nextpc       = br_taken ? br_target : fs_pc + 32'd4;
      state_nxt    = state;
      inst_buf_nxt = inst_buf;
      // fs_allowin=0 implies a valid instruction stalled without redirect (LIVE or HOLD).
      if (fs_allowin) begin
         state_nxt = LIVE;
         if (br_taken) begin
            inst_buf_nxt = '0;
         end
      end else if (state == LIVE) begin
         state_nxt    = HOLD;
         inst_buf_nxt = inst_sram_rdata;
      end
   end

   assign inst_sram_en    = resetn & fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = '0;
   assign fs_inst         = (state == HOLD) ? inst_buf : inst_sram_rdata;
   assign fs_to_ds_valid  = fs_valid & ~br_taken;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= EMPTY;
         inst_buf <= '0;
         fs_pc    <= RESET_PC - 32'd4;
      end else begin
         state    <= state_nxt;
         inst_buf <= inst_buf_nxt;
         if (inst_sram_en) begin
            fs_pc <= nextpc;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: SRAM model with one-cycle read latency and a
// scoreboard of expected (pc, inst) deliveries popped on each decode handshake.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h1c00_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] sram_q = '0;
   exp_t        sb_q[$];
   int          n_chk = 0;
   int          n_err = 0;

   if_stage_if bus();

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ds_allowin      (bus.ds_allowin),
      .br_taken        (bus.br_taken),
      .br_target       (bus.br_target),
      .fs_to_ds_valid  (bus.fs_to_ds_valid),
      .fs_pc           (bus.fs_pc),
      .fs_inst         (bus.fs_inst),
      .inst_sram_en    (bus.inst_sram_en),
      .inst_sram_we    (bus.inst_sram_we),
      .inst_sram_addr  (bus.inst_sram_addr),
      .inst_sram_wdata (bus.inst_sram_wdata),
      .inst_sram_rdata (bus.inst_sram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      if (a == 32'h1c00_000c) return 32'h0280_0421;
      return a ^ 32'h5a5a_0f0f;
   endfunction

   // Without a request the read port drifts every cycle, so a held instruction must come from the buffer.
   always @(posedge clk) begin
      if (bus.inst_sram_en) sram_q <= inst_of(bus.inst_sram_addr);
      else                  sram_q <= sram_q + 32'h1111_1111;
   end
   assign bus.inst_sram_rdata = sram_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_t e;
      e.pc   = a;
      e.inst = inst_of(a);
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic ds, input logic br, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      bus.ds_allowin = ds;
      bus.br_taken   = br;
      bus.br_target  = tgt;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (resetn && bus.fs_to_ds_valid && bus.ds_allowin) begin
         if (sb_q.size() == 0) begin
            check("sb_extra", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_pc", bus.fs_pc, e.pc);
            check("sb_inst", bus.fs_inst, e.inst);
         end
      end
   end

   initial begin
      bus.ds_allowin = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_en", {31'd0, bus.inst_sram_en}, 32'd0);
      check("rst_vld", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      check("rst_pc", bus.fs_pc, 32'h1bff_fffc);
      check("rst_we", {31'd0, bus.inst_sram_we}, 32'd0);

      // Reset release and streaming
      @(posedge clk);
      #1;
      resetn = 1'b1;
      bus.ds_allowin = 1'b1;
      push_exp(32'h1c00_0000);
      push_exp(32'h1c00_0004);
      push_exp(32'h1c00_0008);
      @(negedge clk);
      check("rel_en", {31'd0, bus.inst_sram_en}, 32'd1);
      check("rel_addr", bus.inst_sram_addr, RST_PC);
      drive(1'b1, 1'b0, '0);
      check("c1_vld", {31'd0, bus.fs_to_ds_valid}, 32'd1);
      check("c1_pc", bus.fs_pc, 32'h1c00_0000);
      check("c1_addr", bus.inst_sram_addr, 32'h1c00_0004);
      drive(1'b1, 1'b0, '0);
      check("c2_pc", bus.fs_pc, 32'h1c00_0004);
      drive(1'b1, 1'b0, '0);
      check("c3_pc", bus.fs_pc, 32'h1c00_0008);

      // Stall for three cycles on 1c00_000c
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, '0);
         check("stall_pc", bus.fs_pc, 32'h1c00_000c);
         check("stall_en", {31'd0, bus.inst_sram_en}, 32'd0);
         check("stall_inst", bus.fs_inst, 32'h0280_0421);
      end
      push_exp(32'h1c00_000c);
      push_exp(32'h1c00_0010);
      drive(1'b1, 1'b0, '0);
      check("unstall_pc", bus.fs_pc, 32'h1c00_000c);
      check("unstall_addr", bus.inst_sram_addr, 32'h1c00_0010);
      drive(1'b1, 1'b0, '0);

      // Redirect while streaming
      push_exp(32'h1c00_0100);
      drive(1'b1, 1'b1, 32'h1c00_0100);
      check("br_vld", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      check("br_en", {31'd0, bus.inst_sram_en}, 32'd1);
      check("br_addr", bus.inst_sram_addr, 32'h1c00_0100);
      drive(1'b1, 1'b0, '0);
      check("br_pc", bus.fs_pc, 32'h1c00_0100);

      // Redirect while holding a buffered instruction
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
      check("hold_pc", bus.fs_pc, 32'h1c00_0104);
      drive(1'b0, 1'b1, 32'h1c00_0200);
      check("hbr_en", {31'd0, bus.inst_sram_en}, 32'd1);
      check("hbr_addr", bus.inst_sram_addr, 32'h1c00_0200);
      check("hbr_vld", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      drive(1'b0, 1'b0, '0);
      check("hbr_pc", bus.fs_pc, 32'h1c00_0200);
      check("hbr_inst", bus.fs_inst, inst_of(32'h1c00_0200));
      check("hbr_en2", {31'd0, bus.inst_sram_en}, 32'd0);
      push_exp(32'h1c00_0200);
      drive(1'b1, 1'b0, '0);

      // PC wrap-around
      push_exp(32'hffff_fffc);
      push_exp(32'h0000_0000);
      drive(1'b1, 1'b1, 32'hffff_fffc);
      drive(1'b1, 1'b0, '0);
      check("wrap_addr", bus.inst_sram_addr, 32'h0000_0000);
      drive(1'b1, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);

      // Asynchronous reset while holding
      #2;
      resetn = 1'b0;
      sb_q.delete();
      #1;
      check("arst_en", {31'd0, bus.inst_sram_en}, 32'd0);
      check("arst_vld", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      check("arst_pc", bus.fs_pc, 32'h1bff_fffc);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      bus.ds_allowin = 1'b1;
      push_exp(RST_PC);
      @(negedge clk);
      check("rst2_en", {31'd0, bus.inst_sram_en}, 32'd1);
      check("rst2_addr", bus.inst_sram_addr, RST_PC);
      drive(1'b1, 1'b0, '0);
      check("rst2_pc", bus.fs_pc, RST_PC);
      drive(1'b0, 1'b0, '0);

      check("sb_left", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c00_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 SHALL have port br_taken  input  1  one-cycle redirect pulse from decode.
REQ-006 SHALL have port br_target  input  32  redirect address, valid when br_taken=1.
REQ-007 SHALL have port fs_to_ds_valid  output  1  fs_pc/fs_inst valid toward decode.
REQ-008 SHALL have port fs_pc  output  32  PC of the instruction presented.
REQ-009 SHALL have port fs_inst  output  32  instruction presented.
REQ-010 SHALL have port inst_sram_en  output  1  SRAM read request this cycle.
REQ-011 SHALL have port inst_sram_we  output  1  tied 0.
REQ-012 SHALL have port inst_sram_addr  output  32  read address, sampled by SRAM at the clock edge.
REQ-013 SHALL have port inst_sram_wdata  output  32  tied 0.
REQ-014 SHALL have port inst_sram_rdata  input  32  read data, valid exactly one cycle after the request edge.

Function
REQ-015 SHALL compute nextpc = br_taken ? br_target : fs_pc + 4, with 32-bit wrap-around (32'hffff_fffc + 4 = 0).
REQ-016 SHALL define fs_allowin = ~fs_valid | ds_allowin | br_taken.
REQ-017 SHALL drive inst_sram_en = fs_allowin when out of reset, and inst_sram_addr = nextpc, combinationally.
REQ-018 SHALL, on an edge with inst_sram_en=1, load fs_pc<=nextpc and fs_valid<=1; otherwise it SHALL hold fs_pc and fs_valid.
REQ-019 SHALL implement three states: EMPTY (fs_valid=0), LIVE (fs_valid=1, instruction on inst_sram_rdata), and HOLD (fs_valid=1, instruction in inst_buf).
REQ-020 SHALL transition LIVE->HOLD when ds_allowin=0 and br_taken=0, capturing inst_sram_rdata into inst_buf.
REQ-021 SHALL transition HOLD->LIVE when ds_allowin=1 and br_taken=0, because a new fetch is issued.
REQ-022 SHALL transition EMPTY->LIVE on the first request.
REQ-023 SHALL drive fs_inst = inst_buf in HOLD and inst_sram_rdata in LIVE.
REQ-024 SHALL drive fs_to_ds_valid = fs_valid & ~br_taken; the instruction after a taken branch is cancelled (no delay slot).
REQ-025 SHALL, on br_taken, issue a fetch to br_target in the same cycle regardless of ds_allowin and state, discard inst_buf, and enter LIVE next cycle; br_taken takes priority over a stall.
REQ-026 SHALL issue at most one SRAM request per cycle and none while reset is asserted.
REQ-027 SHALL give the pipeline a fetch latency of 1 cycle from request to fs_to_ds_valid=1 and a sustained throughput of 1 instruction per cycle when ds_allowin=1.
REQ-028 SHALL forward br_target unchanged without an alignment check; address exceptions are out of scope.

Reset
REQ-029 SHALL, while resetn=0, force fs_valid=0, state=EMPTY, inst_buf=0, fs_pc=RESET_PC-4 (32'h1bff_fffc), inst_sram_en=0, and fs_to_ds_valid=0, asynchronously.
REQ-030 SHALL, in the first cycle after resetn rises, issue a request to RESET_PC.
REQ-031 SHALL, on reset mid-operation, discard any buffered or in-flight instruction, and no stale fs_to_ds_valid SHALL appear after release.
REQ-032 SHALL require resetn deassertion to be synchronous to clk externally; no internal synchronizer.

Structure
REQ-033 SHALL place RESET_PC, FS_TO_DS_BUS_WD=64, and BR_BUS_WD=33 in the shared cpu package, reused by the decode stage.
REQ-034 SHALL be a single module without sub-modules; the state SHALL be encoded from fs_valid and inst_buf_valid.

Verification
REQ-035 SHALL be covered by a reset release test: resetn rises -> inst_sram_addr=32'h1c00_0000 with en=1 in the first cycle, fs_to_ds_valid=1 with fs_pc=32'h1c00_0000 in the next.
REQ-036 SHALL be covered by a streaming test: ds_allowin=1 for 4 cycles -> fs_pc 1c00_0000, _0004, _0008, _000c on consecutive cycles.
REQ-037 SHALL be covered by a stall test: ds_allowin=0 for 3 cycles while LIVE with rdata=32'h0280_0421 -> inst_sram_en=0, fs_inst stays 32'h0280_0421 while SRAM rdata changes, and no PC is skipped after release.
REQ-038 SHALL be covered by a redirect test: br_taken=1 with br_target=32'h1c00_0100 -> fs_to_ds_valid=0 that cycle, inst_sram_addr=32'h1c00_0100, fs_pc=32'h1c00_0100 next cycle.
REQ-039 SHALL be covered by a redirect-during-stall test: HOLD plus br_taken=1 with ds_allowin=0 -> buffer discarded and a fetch issued to the target.
REQ-040 SHALL be covered by a mid-stream reset test: resetn=0 while HOLD -> outputs reach reset values without a clock edge, and the restart fetches 32'h1c00_0000.
